// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and port indices.
package dmem_arb_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GNT_CPU = 2'd1;
   localparam logic [1:0] GNT_DBG = 2'd2;
   localparam logic [1:0] RESP    = 2'd3;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   function automatic logic [1:0] gnt_state(input logic port);
      return (port == PORT_DBG) ? GNT_DBG : GNT_CPU;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; on a tie the port that did not win last time wins.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_gnt,
   output logic       o_vld
);

   always_comb begin
      o_vld = |i_req;
      if (&i_req)
         o_gnt = ~i_last;
      else if (i_req[PORT_DBG])
         o_gnt = PORT_DBG;
      else
         o_gnt = PORT_CPU;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU load/store port and the debug/loader port.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  contention_cnt
);

   logic [1:0]        r_state;
   logic              r_last_gnt;
   logic              r_cpu_ack;
   logic              r_dbg_ack;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dbg_rdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_mem_re;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic              w_arb;
   logic              w_gnt;
   logic              w_vld;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   rr_pick2 u_pick (
      .i_req  ({dbg_req, cpu_req}),
      .i_last (r_last_gnt),
      .o_gnt  (w_gnt),
      .o_vld  (w_vld)
   );

   assign w_arb       = (r_state == IDLE) || (r_state == RESP);
   assign w_sel_we    = (w_gnt == PORT_DBG) ? dbg_we    : cpu_we;
   assign w_sel_addr  = (w_gnt == PORT_DBG) ? dbg_addr  : cpu_addr;
   assign w_sel_wdata = (w_gnt == PORT_DBG) ? dbg_wdata : cpu_wdata;

   // RAM controls are registered at the arbitration edge, so an async reset
   // during the access cycle removes mem_we before the RAM can commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_last_gnt  <= PORT_DBG;
         r_cpu_ack   <= 1'b0;
         r_dbg_ack   <= 1'b0;
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
         r_cnt       <= '0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_cpu_ack <= 1'b0;
         r_dbg_ack <= 1'b0;
         case (r_state)
            IDLE, RESP: begin
               if (w_vld) begin
                  r_state     <= gnt_state(w_gnt);
                  r_last_gnt  <= w_gnt;
                  r_mem_re    <= ~w_sel_we;
                  r_mem_we    <= w_sel_we;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
               end else begin
                  r_state <= IDLE;
               end
            end
            GNT_CPU: begin
               r_cpu_ack <= 1'b1;
               if (!r_mem_we) r_cpu_rdata <= mem_rdata;
               r_mem_re  <= 1'b0;
               r_mem_we  <= 1'b0;
               r_state   <= RESP;
            end
            GNT_DBG: begin
               r_dbg_ack <= 1'b1;
               if (!r_mem_we) r_dbg_rdata <= mem_rdata;
               r_mem_re  <= 1'b0;
               r_mem_we  <= 1'b0;
               r_state   <= RESP;
            end
            default: r_state <= IDLE;
         endcase
         if (w_arb && cpu_req && dbg_req) r_cnt <= sat_inc(r_cnt);
      end
   end

   assign cpu_ack        = r_cpu_ack;
   assign dbg_ack        = r_dbg_ack;
   assign cpu_rdata      = r_cpu_rdata;
   assign dbg_rdata      = r_dbg_rdata;
   assign cpu_stall      = cpu_req & ~r_cpu_ack;
   assign mem_re         = r_mem_re;
   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_wdata      = r_mem_wdata;
   assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ack, cpu_stall;
   logic        dbg_req, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata;
   logic [31:0] dbg_rdata;
   logic        dbg_ack;
   logic        mem_re, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  contention_cnt;

   logic [31:0] ram [0:63];
   logic [31:0] mdl [0:63];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .contention_cnt(contention_cnt)
   );

   // Simple RAM: combinational read, write commits on the clock edge.
   assign mem_rdata = ram[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input string tag);
      int  n;
      bit  got;
      n = 0;
      got = 1'b0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      while (!got && n < 6) begin
         tick();
         n++;
         if (cpu_ack) got = 1'b1;
         else check({tag, "_stall"}, cpu_stall, 1'b1);
      end
      check({tag, "_ack"}, got, 1'b1);
      if (got) begin
         if (we) mdl[addr[7:2]] = wdata;
         else check({tag, "_rdata"}, cpu_rdata, mdl[addr[7:2]]);
      end
      cpu_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        busy  [2];
      logic        op_we [2];
      logic [31:0] op_ad [2];
      logic [31:0] op_wd [2];
      int          age   [2];
      logic [31:0] exp_rd[2];
      logic        acks  [2];
      logic [31:0] rds   [2];
      int          nack;

      for (int i = 0; i < 64; i++) begin
         ram[i] = 32'hA500_0000 | i;
         mdl[i] = 32'hA500_0000 | i;
      end
      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      tick();
      tick();

      // Reset state
      check("rst_cpu_ack", cpu_ack, 1'b0);
      check("rst_dbg_ack", dbg_ack, 1'b0);
      check("rst_cpu_rdata", cpu_rdata, 32'h0);
      check("rst_dbg_rdata", dbg_rdata, 32'h0);
      check("rst_cnt", contention_cnt, 4'h0);
      check("rst_mem_re", mem_re, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_stall", cpu_stall, 1'b0);

      // First load after reset: ack two edges after the request
      rst = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
      tick();
      check("ld_mem_re", mem_re, 1'b1);
      check("ld_mem_addr", mem_addr, 32'h4);
      check("ld_ack_early", cpu_ack, 1'b0);
      check("ld_stall", cpu_stall, 1'b1);
      tick();
      check("ld_ack", cpu_ack, 1'b1);
      check("ld_rdata", cpu_rdata, mdl[1]);
      check("ld_stall_ack", cpu_stall, 1'b0);
      check("ld_mem_re_off", mem_re, 1'b0);
      cpu_req = 1'b0;
      tick();
      check("ld_ack_pulse", cpu_ack, 1'b0);

      // CPU store then load of 0x10
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      tick();
      check("st_mem_we", mem_we, 1'b1);
      check("st_mem_addr", mem_addr, 32'h10);
      check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      check("st_stall", cpu_stall, 1'b1);
      tick();
      check("st_ack", cpu_ack, 1'b1);
      check("st_mem_we_off", mem_we, 1'b0);
      check("st_stall_ack", cpu_stall, 1'b0);
      check("st_rdata_hold", cpu_rdata, mdl[1]);
      mdl[4] = 32'hDEADBEEF;
      cpu_we = 1'b0;
      tick();
      check("ld2_mem_re", mem_re, 1'b1);
      check("ld2_stall", cpu_stall, 1'b1);
      tick();
      check("ld2_ack", cpu_ack, 1'b1);
      check("ld2_rdata", cpu_rdata, 32'hDEADBEEF);
      cpu_req = 1'b0;
      tick();

      // Async reset in the middle of a CPU write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h1234;
      tick();
      check("mr_mem_we_pre", mem_we, 1'b1);
      #1;
      rst = 1'b1;
      cpu_req = 1'b0;
      #1;
      check("mr_mem_we", mem_we, 1'b0);
      check("mr_mem_re", mem_re, 1'b0);
      check("mr_mem_addr", mem_addr, 32'h0);
      check("mr_mem_wdata", mem_wdata, 32'h0);
      check("mr_cpu_rdata", cpu_rdata, 32'h0);
      check("mr_cpu_ack", cpu_ack, 1'b0);
      check("mr_stall", cpu_stall, 1'b0);
      tick();
      check("mr_no_ack", cpu_ack, 1'b0);

      // Continuous contention from reset: strict alternation and counter saturation
      rst = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
      for (int k = 1; k <= 40; k++) begin
         tick();
         check("ct_cpu_ack", cpu_ack, (k % 4) == 2);
         check("ct_dbg_ack", dbg_ack, (k % 4) == 0);
         check("ct_cnt", contention_cnt, 32'((((k + 1) / 2) > 15) ? 15 : (k + 1) / 2));
         if (cpu_ack) check("ct_cpu_rdata", cpu_rdata, mdl[1]);
         if (dbg_ack) check("ct_dbg_rdata", dbg_rdata, mdl[4]);
      end
      check("ct_cnt_sat", contention_cnt, 4'hF);
      do_reset();

      // Debug preload of four words, back-to-back
      nack = 0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0; dbg_wdata = 32'h1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("pl_dbg_ack", dbg_ack, (k % 2) == 0);
         if (dbg_ack) begin
            mdl[nack] = nack + 1;
            nack++;
            if (nack < 4) begin
               dbg_addr = 32'(4 * nack);
               dbg_wdata = 32'(nack + 1);
            end else begin
               dbg_req = 1'b0;
            end
         end
      end
      check("pl_ack_count", nack, 4);
      cpu_op(1'b0, 32'h8, 32'h0, "pl_cpu_ld");
      check("pl_val_0x8", cpu_rdata, 32'h3);

      // Reset during a debug write: no ack, RAM keeps its prior value
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h55;
      tick();
      check("rw_mem_we_pre", mem_we, 1'b1);
      check("rw_mem_addr", mem_addr, 32'h20);
      #1;
      rst = 1'b1;
      dbg_req = 1'b0;
      #1;
      check("rw_mem_we", mem_we, 1'b0);
      tick();
      check("rw_no_ack1", dbg_ack, 1'b0);
      rst = 1'b0;
      tick();
      check("rw_no_ack2", dbg_ack, 1'b0);
      cpu_op(1'b0, 32'h20, 32'h0, "rw_cpu_ld");
      check("rw_prior", cpu_rdata, 32'hA500_0008);

      // Randomized traffic on both ports against the memory model
      exp_rd[0] = 32'hA500_0008;
      exp_rd[1] = 32'h0;
      for (int p = 0; p < 2; p++) begin
         busy[p] = 1'b0; op_we[p] = 1'b0; op_ad[p] = '0; op_wd[p] = '0; age[p] = 0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         tick();
         check("rnd_stall", cpu_stall, cpu_req & ~cpu_ack);
         acks[0] = cpu_ack; acks[1] = dbg_ack;
         rds[0]  = cpu_rdata; rds[1] = dbg_rdata;
         for (int p = 0; p < 2; p++) begin
            if (busy[p]) begin
               age[p]++;
               if (acks[p]) begin
                  if (op_we[p]) begin
                     mdl[op_ad[p][7:2]] = op_wd[p];
                     check(p ? "rnd_dbg_rd_hold" : "rnd_cpu_rd_hold", rds[p], exp_rd[p]);
                  end else begin
                     exp_rd[p] = mdl[op_ad[p][7:2]];
                     check(p ? "rnd_dbg_rdata" : "rnd_cpu_rdata", rds[p], exp_rd[p]);
                  end
                  busy[p] = 1'b0;
               end else if (age[p] >= 4) begin
                  check(p ? "rnd_dbg_latency" : "rnd_cpu_latency", acks[p], 1'b1);
                  busy[p] = 1'b0;
               end
            end else begin
               check(p ? "rnd_dbg_spurious" : "rnd_cpu_spurious", acks[p], 1'b0);
            end
            if (!busy[p] && $urandom_range(0, 2) != 0) begin
               busy[p]  = 1'b1;
               age[p]   = 0;
               op_we[p] = 1'($urandom_range(0, 1));
               op_ad[p] = 32'($urandom_range(0, 15)) << 2;
               op_wd[p] = $urandom;
            end
         end
         cpu_req = busy[0]; cpu_we = op_we[0]; cpu_addr = op_ad[0]; cpu_wdata = op_wd[0];
         dbg_req = busy[1]; dbg_we = op_we[1]; dbg_addr = op_ad[1]; dbg_wdata = op_wd[1];
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
